// File: rtl/siso_pkg.sv
// siso_pkg: shared types, constants and metric reduction for the SISO decoder; BETA_SAT_EN selects saturation over wrap
package siso_pkg;
  localparam int NUM_STATES = 8;
  localparam int MW = 16;
  typedef logic signed [MW-1:0] metric_t;
  typedef metric_t [NUM_STATES-1:0] beta_vec_t;
  typedef enum logic [1:0] {IDLE, LOAD, PRIME, RUN} fsm_t;
  function automatic logic signed [31:0] sat_trunc(input logic signed [31:0] x, input int w);
`ifdef BETA_SAT_EN
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return x > hi ? hi : x < -hi - 32'sd1 ? -hi - 32'sd1 : x;
`else
    return (x <<< (32 - w)) >>> (32 - w);
`endif
  endfunction
endpackage

// File: rtl/beta_recursion_branch_lifo.sv
// branch_lifo: simple dual-port frame buffer with synchronous write and stallable registered read
module branch_lifo #(
  parameter int DW = 32,
  parameter int DEPTH = 516,
  parameter int AW = 10
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [DW-1:0] wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write port and read register; read holds its value when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/beta_recursion.sv
// beta_recursion: backward max-log-MAP state metrics over a buffered frame; BETA_SAT_EN saturates metrics instead of wrapping
module beta_recursion
  import siso_pkg::*;
#(
  parameter int W = 16,
  parameter int MAX_LEN = 516,
  parameter int AW = $clog2(MAX_LEN),
  parameter int NEG_INIT = -128
) (
  input logic clk,
  input logic rst,
  input logic [15:0] blklen,
  input logic valid_branch,
  input logic signed [W-1:0] init_branch1,
  input logic signed [W-1:0] init_branch2,
  output logic in_ready,
  output logic [NUM_STATES*W-1:0] beta_out,
  output logic [AW-1:0] beta_idx,
  output logic valid_beta,
  output logic beta_last,
  input logic beta_ready,
  output logic len_err
);
  fsm_t st, nxt;
  logic [AW-1:0] wr_cnt, last_idx, k, waddr, raddr;
  logic we, re, fire, len_ok;
  logic [2*W-1:0] rdata;
  logic signed [W-1:0] mreg [NUM_STATES];
  logic signed [W+1:0] ob [NUM_STATES];
  logic signed [W+1:0] raw [NUM_STATES];
  logic signed [W+1:0] g1, g2;
  logic signed [31:0] wide [NUM_STATES];
  logic signed [W-1:0] nb [NUM_STATES];
  logic [NUM_STATES*W-1:0] nvec;

  function automatic logic signed [W+1:0] smax(input logic signed [W+1:0] a, input logic signed [W+1:0] b);
    return a > b ? a : b;
  endfunction

  assign len_ok = blklen != 16'd0 && 32'(blklen) <= MAX_LEN;
  assign waddr = st == IDLE ? '0 : wr_cnt;

  branch_lifo #(.DW(2*W), .DEPTH(MAX_LEN), .AW(AW)) u_lifo (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata({init_branch2, init_branch1}),
    .re(re),
    .raddr(raddr),
    .rdata(rdata)
  );

  // one trellis step backwards from the metric register, normalised to state 0 and reduced to W bits
  always_comb begin
    nvec = '0;
    g1 = (W+2)'($signed(rdata[W-1:0]));
    g2 = (W+2)'($signed(rdata[2*W-1:W]));
    for (int j = 0; j < NUM_STATES; j++) ob[j] = (W+2)'(mreg[j]);
    raw[0] = smax(ob[0] + g1, ob[4] - g1);
    raw[1] = smax(ob[4] + g1, ob[0] - g1);
    raw[2] = smax(ob[5] + g2, ob[1] - g2);
    raw[3] = smax(ob[1] + g2, ob[5] - g2);
    raw[4] = smax(ob[2] + g2, ob[6] - g2);
    raw[5] = smax(ob[6] + g2, ob[2] - g2);
    raw[6] = smax(ob[7] + g1, ob[3] - g1);
    raw[7] = smax(ob[3] + g1, ob[7] - g1);
    for (int j = 0; j < NUM_STATES; j++) begin
      wide[j] = 32'(raw[j] - raw[0]);
      nb[j] = W'(sat_trunc(wide[j], W));
      nvec[j*W +: W] = nb[j];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else st <= nxt;
  end

  // next state, input acceptance and LIFO control; a step fires when the output slot is free or draining
  always_comb begin
    nxt = st;
    in_ready = 1'b0;
    we = 1'b0;
    re = 1'b0;
    fire = 1'b0;
    raddr = k - AW'(1);
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        we = valid_branch && len_ok;
        if (we) nxt = blklen == 16'd1 ? PRIME : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        we = valid_branch;
        if (we && wr_cnt == last_idx) nxt = PRIME;
      end
      PRIME: begin
        re = 1'b1;
        raddr = last_idx;
        nxt = RUN;
      end
      RUN: begin
        fire = !(valid_beta && beta_last) && (!valid_beta || beta_ready);
        re = fire;
        if (valid_beta && beta_last && beta_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // counters, metric register and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      last_idx <= '0;
      k <= '0;
      len_err <= 1'b0;
      valid_beta <= 1'b0;
      beta_last <= 1'b0;
      beta_out <= '0;
      beta_idx <= '0;
      for (int j = 0; j < NUM_STATES; j++) mreg[j] <= j == 0 ? '0 : W'(NEG_INIT);
    end else begin
      len_err <= st == IDLE && valid_branch && !len_ok;
      if (st == IDLE && we) begin
        wr_cnt <= AW'(1);
        last_idx <= AW'(blklen - 16'd1);
      end else if (we) wr_cnt <= wr_cnt + AW'(1);
      if (st == PRIME) begin
        k <= last_idx;
        for (int j = 0; j < NUM_STATES; j++) mreg[j] <= j == 0 ? '0 : W'(NEG_INIT);
      end
      if (fire) begin
        beta_out <= nvec;
        beta_idx <= k;
        beta_last <= k == '0;
        valid_beta <= 1'b1;
        k <= k - AW'(1);
        for (int j = 0; j < NUM_STATES; j++) mreg[j] <= nb[j];
      end else if (valid_beta && beta_ready && beta_last) begin
        valid_beta <= 1'b0;
        beta_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_beta_recursion.sv
// tb_beta_recursion: table vectors plus random frames against a behavioural beta recursion model
module tb_beta_recursion;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] blklen;
  logic valid_branch;
  logic signed [15:0] init_branch1, init_branch2;
  logic in_ready, valid_beta, beta_last, beta_ready, len_err;
  logic [127:0] beta_out;
  logic [9:0] beta_idx;
  logic [15:0] blklen8;
  logic valid8, in_ready8, vb8, last8, ready8, err8;
  logic signed [7:0] g1_8, g2_8;
  logic [63:0] out8;
  logic [3:0] idx8;

  int total = 0;
  int bad = 0;
  int mb[8];
  int g1q[516];
  int g2q[516];
  logic [127:0] expv[516];
  int sa[8] = '{0, 4, 5, 1, 2, 6, 7, 3};
  int sb[8] = '{4, 0, 1, 5, 6, 2, 3, 7};
  bit ug2[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  bit pat[4] = '{1, 0, 0, 1};

  typedef struct {
    int g1;
    int g2;
    int b[8];
  } vec_t;
  vec_t tbl[3];

  beta_recursion dut (
    .clk(clk), .rst(rst), .blklen(blklen), .valid_branch(valid_branch),
    .init_branch1(init_branch1), .init_branch2(init_branch2), .in_ready(in_ready),
    .beta_out(beta_out), .beta_idx(beta_idx), .valid_beta(valid_beta),
    .beta_last(beta_last), .beta_ready(beta_ready), .len_err(len_err)
  );

  beta_recursion #(.W(8), .MAX_LEN(16)) dut8 (
    .clk(clk), .rst(rst), .blklen(blklen8), .valid_branch(valid8),
    .init_branch1(g1_8), .init_branch2(g2_8), .in_ready(in_ready8),
    .beta_out(out8), .beta_idx(idx8), .valid_beta(vb8),
    .beta_last(last8), .beta_ready(ready8), .len_err(err8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int red(input longint x, input int w);
    longint m, hi, lo, r;
    m = longint'(1) << w;
    hi = (m >> 1) - 1;
    lo = -(m >> 1);
`ifdef BETA_SAT_EN
    r = x > hi ? hi : x < lo ? lo : x;
`else
    r = ((x % m) + m) % m;
    if (r > hi) r = r - m;
`endif
    return int'(r);
  endfunction

  task automatic init_model();
    for (int j = 0; j < 8; j++) mb[j] = j == 0 ? 0 : -128;
  endtask

  task automatic step(input int g1, input int g2, input int w);
    longint nw[8];
    longint g, a, b;
    for (int j = 0; j < 8; j++) begin
      g = ug2[j] ? g2 : g1;
      a = mb[sa[j]] + g;
      b = mb[sb[j]] - g;
      nw[j] = a > b ? a : b;
    end
    for (int j = 0; j < 8; j++) mb[j] = red(nw[j] - nw[0], w);
  endtask

  function automatic logic [127:0] pack(input int w);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 8; j++)
      for (int b = 0; b < w; b++) v[j*w+b] = mb[j][b];
    return v;
  endfunction

  task automatic model_frame(input int n);
    init_model();
    for (int k = n - 1; k >= 0; k--) begin
      step(g1q[k], g2q[k], 16);
      expv[k] = pack(16);
    end
  endtask

  task automatic gen(input int n);
    for (int i = 0; i < n; i++) begin
      g1q[i] = int'($urandom_range(0, 65535)) - 32768;
      g2q[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic send_frame(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      valid_branch = 1'b1;
      blklen = i == 0 ? 16'(len) : 16'($urandom);
      init_branch1 = 16'(g1q[i]);
      init_branch2 = 16'(g2q[i]);
      @(negedge clk);
    end
    valid_branch = 1'b0;
  endtask

  task automatic collect(input int n, input bit stall, input bit junk);
    int got, cyc, first, k;
    bit hv;
    logic [127:0] hvec;
    logic [9:0] hidx;
    got = 0;
    cyc = 0;
    first = -1;
    hv = 1'b0;
    while (got < n && cyc < 4000) begin
      beta_ready = stall ? pat[cyc % 4] : 1'b1;
      if (junk) begin
        valid_branch = 1'b1;
        blklen = 16'd3;
        init_branch1 = 16'($urandom);
        init_branch2 = 16'($urandom);
      end
      if (hv) begin
        chk("hold_vec", beta_out, hvec);
        chk("hold_idx", beta_idx, hidx);
      end
      hv = valid_beta && !beta_ready;
      hvec = beta_out;
      hidx = beta_idx;
      if (valid_beta) begin
        if (first < 0) first = cyc;
        if (beta_ready) begin
          k = n - 1 - got;
          chk("idx", beta_idx, k);
          chk("vec", beta_out, expv[k]);
          chk("last", beta_last, k == 0);
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    valid_branch = 1'b0;
    chk("count", got, n);
    chk("latency", first, 2);
    chk("idle_valid", valid_beta, 1'b0);
    chk("idle_ready", in_ready, 1'b1);
    beta_ready = 1'b1;
  endtask

  initial begin
    int seen;
    tbl[0] = '{g1: 10, g2: 5, b: '{0, -20, -133, -133, -133, -133, -128, -128}};
    tbl[1] = '{g1: 0, g2: 0, b: '{0, 0, -128, -128, -128, -128, -128, -128}};
    tbl[2] = '{g1: -10, g2: 3, b: '{0, 20, -115, -115, -115, -115, -108, -108}};
    rst = 1'b0;
    blklen = '0;
    valid_branch = 1'b0;
    init_branch1 = '0;
    init_branch2 = '0;
    beta_ready = 1'b1;
    blklen8 = '0;
    valid8 = 1'b0;
    g1_8 = '0;
    g2_8 = '0;
    ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_valid", valid_beta, 1'b0);
    chk("rst_out", beta_out, 128'd0);
    chk("rst_idx", beta_idx, 10'd0);
    chk("rst_last", beta_last, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      g1q[0] = tbl[t].g1;
      g2q[0] = tbl[t].g2;
      for (int j = 0; j < 8; j++) expv[0][j*16 +: 16] = 16'(tbl[t].b[j]);
      send_frame(1, 1);
      collect(1, 1'b0, 1'b0);
    end
    valid8 = 1'b1;
    blklen8 = 16'd1;
    g1_8 = 8'sd100;
    g2_8 = 8'sd0;
    @(negedge clk);
    valid8 = 1'b0;
    init_model();
    step(100, 0, 8);
    @(negedge clk);
    chk("w8_early", vb8, 1'b0);
    @(negedge clk);
    chk("w8_valid", vb8, 1'b1);
    chk("w8_vec", out8, pack(8));
    chk("w8_last", last8, 1'b1);
    @(negedge clk);
    gen(516);
    model_frame(516);
    send_frame(516, 516);
    collect(516, 1'b0, 1'b1);
    send_frame(516, 516);
    collect(516, 1'b1, 1'b0);
    foreach (tbl[t]) begin
      blklen = t == 0 ? 16'd0 : 16'd517;
      valid_branch = 1'b1;
      @(negedge clk);
      valid_branch = 1'b0;
      chk("len_err_pulse", len_err, 1'b1);
      chk("len_err_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("len_err_once", len_err, 1'b0);
      chk("len_err_nout", valid_beta, 1'b0);
      if (t == 1) break;
    end
    gen(4);
    model_frame(4);
    send_frame(4, 4);
    collect(4, 1'b0, 1'b0);
    gen(8);
    send_frame(8, 8);
    seen = 0;
    while (!(valid_beta && beta_idx == 10'd5) && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("abort_reach", beta_idx, 10'd5);
    rst = 1'b0;
    #1;
    chk("abort_valid", valid_beta, 1'b0);
    chk("abort_out", beta_out, 128'd0);
    chk("abort_idx", beta_idx, 10'd0);
    chk("abort_last", beta_last, 1'b0);
    chk("abort_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", valid_beta, 1'b0);
      chk("post_rst_ready", in_ready, 1'b1);
    end
    gen(2);
    model_frame(2);
    send_frame(2, 2);
    collect(2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
